// File: rtl/core_axi_bridge.sv
// Bridges the core's instruction/data SRAM-style ports onto one AXI3 master port.
// Each request is served as single-beat transactions, data first, with a bus stall until done.
module core_axi_bridge (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  // load/store port
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_bus,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, D_AR, D_R, D_AW, D_B, I_AR, I_R, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] d_addr_q, d_wdata_q, i_addr_q;
  logic [3:0]  d_wen_q;
  logic        i_en_q;
  logic        aw_done, w_done;
  logic        aw_hs, w_hs;

  // Only one transaction is ever outstanding, so ids and responses carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp, inst_sram_wen, inst_sram_wdata};

  assign arlen   = 4'd0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awid    = 4'd1;
  assign awaddr  = d_addr_q;
  assign awlen   = 4'd0;
  assign awsize  = 3'd2;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wdata   = d_wdata_q;
  assign wstrb   = d_wen_q;
  assign wlast   = 1'b1;

  assign stallreq_for_bus = (inst_sram_en | data_sram_en) & (state != DONE) & ~rst;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    arid      = 4'd1;
    araddr    = d_addr_q;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state)
      IDLE: begin
        if (data_sram_en)      state_nxt = (data_sram_wen == 4'd0) ? D_AR : D_AW;
        else if (inst_sram_en) state_nxt = I_AR;
      end
      D_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = D_R;
      end
      D_R: begin
        rready = 1'b1;
        if (rvalid) state_nxt = i_en_q ? I_AR : DONE;
      end
      D_AW: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = D_B;
      end
      D_B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = i_en_q ? I_AR : DONE;
      end
      I_AR: begin
        arvalid = 1'b1;
        arid    = 4'd0;
        araddr  = i_addr_q;
        if (arready) state_nxt = I_R;
      end
      I_R: begin
        rready = 1'b1;
        if (rvalid) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      inst_sram_rdata <= 32'd0;
      data_sram_rdata <= 32'd0;
    end else begin
      state   <= state_nxt;
      aw_done <= (state == D_AW) & (aw_done | aw_hs);
      w_done  <= (state == D_AW) & (w_done | w_hs);
      if (state == D_R && rvalid) data_sram_rdata <= rdata;
      if (state == I_R && rvalid) inst_sram_rdata <= rdata;
    end
  end

  // NOTE: request capture registers are only read after an IDLE cycle has loaded them,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      d_addr_q  <= data_sram_addr;
      d_wdata_q <= data_sram_wdata;
      d_wen_q   <= data_sram_wen;
      i_en_q    <= inst_sram_en;
      i_addr_q  <= inst_sram_addr;
    end
  end

endmodule
